// File: rtl/lamp_seq_pkg.sv
// Shared types and encodings for the N-lamp sequencer.
// The reserved mode encoding is folded onto rotate here, so the datapath only sees three modes.
package lamp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROTATE = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == MODE_BOUNCE || m == MODE_FILL) ? m : MODE_ROTATE;
    endfunction

endpackage

// File: rtl/lamp_sequencer_step_timer.sv
// Step timer: counts RUN clocks and strobes tick on the last clock of each step period.
module step_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] r_count;

    assign tick = run && (r_count == LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= tick ? '0 : r_count + TW'(1);
        end
    end

endmodule

// File: rtl/lamp_sequencer.sv
// N-lamp sequencer: IDLE (all on), RUN (rotate/bounce/fill pointer), HOLD (all off, frozen).
// Every output decodes from registers only, so lamps follow the inputs with one clock of latency.
module lamp_sequencer
    import lamp_seq_pkg::*;
#(
    parameter int N_LAMPS     = 4,
    parameter int STEP_CYCLES = 1,
    localparam int PW         = (N_LAMPS > 1) ? $clog2(N_LAMPS) : 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               i,
    input  logic               s,
    input  logic               dir,
    input  logic [1:0]         mode,
    output logic [N_LAMPS-1:0] lamps,
    output logic [PW-1:0]      pos,
    output logic               wrap
);

    localparam logic [PW-1:0] LAST = PW'(N_LAMPS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_pos;
    logic [PW-1:0] w_pos_nxt;
    logic          r_bdir;
    logic          w_bdir_eff;
    logic          w_bdir_nxt;
    logic          r_prev_bounce;
    logic          r_fill;
    logic          r_wrap;
    logic          w_wrap_nxt;
    logic          w_tick;
    logic          w_run;
    logic          w_clear;
    logic          w_bounce;
    logic [1:0]    w_mode;

    assign w_run   = (r_state == RUN);
    assign w_clear = (r_state == IDLE);

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .Clock(Clock),
        .Reset(Reset),
        .run  (w_run),
        .clear(w_clear),
        .tick (w_tick)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        lamps        = '0;
        if (!i) begin
            w_next_state = IDLE;
        end else if (s) begin
            w_next_state = HOLD;
        end else begin
            w_next_state = RUN;
        end

        case (r_state)
            IDLE: lamps = '1;
            RUN: begin
                for (int j = 0; j < N_LAMPS; j++) begin
                    lamps[j] = r_fill ? (j <= int'(r_pos)) : (j == int'(r_pos));
                end
            end
            default: lamps = '0;
        endcase
    end

    always_comb begin
        w_mode   = eff_mode(mode);
        w_bounce = (w_mode == MODE_BOUNCE);

        // Entering bounce picks the direction that leads away from the current end.
        w_bdir_eff = r_bdir;
        if (w_bounce && !r_prev_bounce) begin
            w_bdir_eff = (r_pos == LAST) ? DIR_DOWN : DIR_UP;
        end

        w_pos_nxt  = r_pos;
        w_bdir_nxt = w_bounce ? w_bdir_eff : r_bdir;
        w_wrap_nxt = 1'b0;

        if (w_tick) begin
            if (N_LAMPS == 1) begin
                w_pos_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else if (w_bounce) begin
                if (w_bdir_eff == DIR_UP) begin
                    w_pos_nxt = r_pos + PW'(1);
                    if (w_pos_nxt == LAST) begin
                        w_bdir_nxt = DIR_DOWN;
                        w_wrap_nxt = 1'b1;
                    end
                end else begin
                    w_pos_nxt = r_pos - PW'(1);
                    if (w_pos_nxt == '0) begin
                        w_bdir_nxt = DIR_UP;
                        w_wrap_nxt = 1'b1;
                    end
                end
            end else if (dir == DIR_UP) begin
                if (r_pos == LAST) begin
                    w_pos_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos + PW'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    w_pos_nxt  = LAST;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos - PW'(1);
                end
            end
        end
    end

    // Mode history is sampled every clock so bounce entry and fill decode track the last applied mode.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pos         <= '0;
            r_bdir        <= DIR_UP;
            r_prev_bounce <= 1'b0;
            r_fill        <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_pos         <= w_pos_nxt;
            r_bdir        <= w_bdir_nxt;
            r_prev_bounce <= (mode == MODE_BOUNCE);
            r_fill        <= (mode == MODE_FILL);
            r_wrap        <= w_wrap_nxt;
        end
    end

    assign pos  = r_pos;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Bench for lamp_sequencer: three configurations share one stimulus stream and are
// compared every clock against a phase/pointer reference model.
module tb_lamp_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       i     = 1'b0;
    logic       s     = 1'b0;
    logic       dir   = 1'b0;
    logic [1:0] mode  = 2'd0;

    logic [3:0] lamps_a, lamps_b;
    logic [1:0] lamps_c;
    logic [1:0] pos_a, pos_b;
    logic [0:0] pos_c;
    logic       wrap_a, wrap_b, wrap_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    lamp_sequencer #(.N_LAMPS(4), .STEP_CYCLES(3)) u_a (
        .Clock(Clock), .Reset(Reset), .i(i), .s(s), .dir(dir), .mode(mode),
        .lamps(lamps_a), .pos(pos_a), .wrap(wrap_a)
    );
    lamp_sequencer #(.N_LAMPS(4), .STEP_CYCLES(1)) u_b (
        .Clock(Clock), .Reset(Reset), .i(i), .s(s), .dir(dir), .mode(mode),
        .lamps(lamps_b), .pos(pos_b), .wrap(wrap_b)
    );
    lamp_sequencer #(.N_LAMPS(2), .STEP_CYCLES(1)) u_c (
        .Clock(Clock), .Reset(Reset), .i(i), .s(s), .dir(dir), .mode(mode),
        .lamps(lamps_c), .pos(pos_c), .wrap(wrap_c)
    );

    // Reference model: phase 0=all on, 1=sequencing, 2=all off.
    int NL[3] = '{4, 4, 2};
    int ST[3] = '{3, 1, 1};
    int m_ph[3], m_pos[3], m_tmr[3], m_bph[3], m_wrap[3], m_fill[3], m_pmode[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < 3; k++) begin
            m_ph[k] = 0; m_pos[k] = 0; m_tmr[k] = 0; m_bph[k] = 0;
            m_wrap[k] = 0; m_fill[k] = 0; m_pmode[k] = 0;
        end
    endtask

    // Bounce walks a ring of 2n-2 phases folded onto positions 0..n-1..1.
    function automatic int fold(int b, int n);
        return (b < n) ? b : 2 * n - 2 - b;
    endfunction

    task automatic mdl_clock();
        int n, md;
        bit stp;
        md = int'(mode);
        for (int k = 0; k < 3; k++) begin
            n   = NL[k];
            stp = 1'b0;
            if (m_ph[k] == 1) begin
                if (m_tmr[k] == ST[k] - 1) begin stp = 1'b1; m_tmr[k] = 0; end
                else m_tmr[k]++;
            end else if (m_ph[k] == 0) begin
                m_tmr[k] = 0;
            end
            if (md == 1 && m_pmode[k] != 1)
                m_bph[k] = (m_pos[k] == n - 1) ? n - 1 : m_pos[k];
            m_wrap[k] = 0;
            if (stp) begin
                if (n == 1) begin
                    m_wrap[k] = 1;
                end else if (md == 1) begin
                    m_bph[k] = (m_bph[k] + 1) % (2 * n - 2);
                    m_pos[k] = fold(m_bph[k], n);
                    m_wrap[k] = (m_pos[k] == 0 || m_pos[k] == n - 1);
                end else if (dir == 1'b0) begin
                    m_pos[k] = (m_pos[k] + 1) % n;
                    m_wrap[k] = (m_pos[k] == 0);
                end else begin
                    m_pos[k] = (m_pos[k] + n - 1) % n;
                    m_wrap[k] = (m_pos[k] == n - 1);
                end
            end
            m_fill[k]  = (md == 2);
            m_pmode[k] = md;
            m_ph[k]    = !i ? 0 : (s ? 2 : 1);
        end
    endtask

    function automatic logic [31:0] exp_lamps(int k);
        if (m_ph[k] == 0) return 32'((1 << NL[k]) - 1);
        if (m_ph[k] == 2) return 32'd0;
        if (m_fill[k] != 0) return 32'((1 << (m_pos[k] + 1)) - 1);
        return 32'(1 << m_pos[k]);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".La"}, 32'(lamps_a), exp_lamps(0));
        chk({tag, ".Pa"}, 32'(pos_a),   32'(m_pos[0]));
        chk({tag, ".Wa"}, 32'(wrap_a),  32'(m_wrap[0]));
        chk({tag, ".Lb"}, 32'(lamps_b), exp_lamps(1));
        chk({tag, ".Pb"}, 32'(pos_b),   32'(m_pos[1]));
        chk({tag, ".Wb"}, 32'(wrap_b),  32'(m_wrap[1]));
        chk({tag, ".Lc"}, 32'(lamps_c), exp_lamps(2));
        chk({tag, ".Pc"}, 32'(pos_c),   32'(m_pos[2]));
        chk({tag, ".Wc"}, 32'(wrap_c),  32'(m_wrap[2]));
    endtask

    task automatic cyc(input string tag);
        @(posedge Clock);
        mdl_clock();
        #1;
        check_all(tag);
    endtask

    // Asserts reset away from any clock edge and checks the outputs before the next edge.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        mdl_reset();
        check_all("rst");
        chk("rst_lamps_a", 32'(lamps_a), 32'hF);
        chk("rst_lamps_c", 32'(lamps_c), 32'h3);
        chk("rst_pos_c",   32'(pos_c),   32'h0);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        int bseq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        #1;
        do_reset();

        i = 1'b0;
        repeat (10) cyc("idle");
        chk("idle_lamps", 32'(lamps_a), 32'hF);

        i = 1'b1; s = 1'b0; mode = 2'd0; dir = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            cyc("rot");
            if (c == 3)  chk("rot_hold3", 32'(lamps_a), 32'h1);
            if (c == 4)  chk("rot_step1", 32'(lamps_a), 32'h2);
            if (c == 12) chk("rot_nowrap", 32'(wrap_a), 32'h0);
            if (c == 13) begin
                chk("rot_back", 32'(lamps_a), 32'h1);
                chk("rot_wrap", 32'(wrap_a),  32'h1);
            end
            if (c == 14) chk("rot_wrap_end", 32'(wrap_a), 32'h0);
        end

        do_reset();
        i = 1'b1; mode = 2'd1;
        for (int c = 0; c < 8; c++) begin
            dir = 1'($urandom_range(0, 1));
            cyc("bnc");
            chk("bnc_pos",  32'(pos_b),  32'(bseq[c]));
            chk("bnc_wrap", 32'(wrap_b), (c == 3 || c == 6) ? 32'h1 : 32'h0);
        end

        do_reset();
        i = 1'b1; mode = 2'd2; dir = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            cyc("fill");
            if (c == 4) begin
                chk("fill_all", 32'(lamps_a), 32'hF);
                chk("fill_pos", 32'(pos_a),   32'h3);
                chk("fill_wrap", 32'(wrap_a), 32'h1);
            end
            if (c == 7)  chk("fill_3", 32'(lamps_a), 32'h7);
            if (c == 10) chk("fill_2", 32'(lamps_a), 32'h3);
            if (c == 13) chk("fill_1", 32'(lamps_a), 32'h1);
        end

        do_reset();
        i = 1'b1; mode = 2'd0; dir = 1'b0;
        repeat (8) cyc("pre");
        s = 1'b1;
        repeat (5) begin
            cyc("hold");
            chk("hold_lamps", 32'(lamps_a), 32'h0);
            chk("hold_pos",   32'(pos_a),   32'h2);
        end
        s = 1'b0;
        cyc("resume");
        chk("resume_0100", 32'(lamps_a), 32'h4);
        cyc("resume");
        chk("resume_1000", 32'(lamps_a), 32'h8);

        do_reset();
        i = 1'b1; mode = 2'd0; dir = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            cyc("alt");
            chk("alt_lamps", 32'(lamps_c), (c % 2 == 1) ? 32'h1 : 32'h2);
        end
        #2;
        do_reset();

        for (int c = 0; c < 400; c++) begin
            i = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
            cyc("rnd");
            if ($urandom_range(0, 99) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
